// File: rtl/bus_controller.sv
// Bus master stage between the CPU control unit and the memory/peripheral port.
// Runs one req/ready transaction per start pulse, with a misalignment check and a wait-state timeout.
module bus_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BUS_start_transaction,
    input  logic              BUS_mode,
    input  logic [ADDR_W-1:0] BUS_addr,
    input  logic [DATA_W-1:0] BUS_wdata,
    output logic [DATA_W-1:0] BUS_rdata,
    output logic              BUS_rdata_valid,
    output logic              BUS_write_done,
    output logic              BUS_err,
    output logic              BUS_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_r, state_s;
    logic              mode_r, mode_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic [7:0]        wait_cnt_r, wait_cnt_s;

    logic              req_r, req_s;
    logic              we_r, we_s;
    logic              rdata_valid_r, rdata_valid_s;
    logic              write_done_r, write_done_s;
    logic              err_r, err_s;
    logic              busy_r, busy_s;

    // Next-state, latch and output decode; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        rdata_s    = rdata_r;
        wait_cnt_s = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (BUS_start_transaction) begin
                    mode_s  = BUS_mode;
                    addr_s  = BUS_addr;
                    wdata_s = BUS_wdata;
                    if (BUS_addr[1:0] != 2'b00) begin
                        state_s = ST_ERR;
                        // A failed read must not leave stale data looking valid.
                        if (!BUS_mode) begin
                            rdata_s = {DATA_W{1'b0}};
                        end else begin
                            rdata_s = rdata_r;
                        end
                    end else begin
                        wait_cnt_s = 8'd0;
                        state_s    = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (!mode_r) begin
                        rdata_s = mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    state_s = ST_DONE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    if (!mode_r) begin
                        rdata_s = {DATA_W{1'b0}};
                    end else begin
                        rdata_s = rdata_r;
                    end
                    state_s = ST_ERR;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                    state_s    = ST_REQ;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase

        req_s         = (state_s == ST_REQ);
        we_s          = (state_s == ST_REQ) && mode_s;
        err_s         = (state_s == ST_ERR);
        busy_s        = (state_s != ST_IDLE);
        rdata_valid_s = ((state_s == ST_DONE) || (state_s == ST_ERR)) && !mode_s;
        write_done_s  = ((state_s == ST_DONE) || (state_s == ST_ERR)) && mode_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction latches, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r        <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            rdata_r       <= {DATA_W{1'b0}};
            wait_cnt_r    <= 8'd0;
            req_r         <= 1'b0;
            we_r          <= 1'b0;
            rdata_valid_r <= 1'b0;
            write_done_r  <= 1'b0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            mode_r        <= mode_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            rdata_r       <= rdata_s;
            wait_cnt_r    <= wait_cnt_s;
            req_r         <= req_s;
            we_r          <= we_s;
            rdata_valid_r <= rdata_valid_s;
            write_done_r  <= write_done_s;
            err_r         <= err_s;
            busy_r        <= busy_s;
        end
    end

    assign BUS_rdata       = rdata_r;
    assign BUS_rdata_valid = rdata_valid_r;
    assign BUS_write_done  = write_done_r;
    assign BUS_err         = err_r;
    assign BUS_busy        = busy_r;
    assign mem_req         = req_r;
    assign mem_we          = we_r;
    assign mem_addr        = addr_r;
    assign mem_wdata       = wdata_r;

endmodule
